// File: rtl/ofdm_rx_deframer.sv
// Receive-side time-domain deframer: splits the preamble onto a training stream,
// strips each cyclic prefix and forwards indexed FFT body samples.
module ofdm_rx_deframer #(
    parameter int TRAIN_LEN = 320,
    parameter int CP_LEN    = 16,
    parameter int FFT_LEN   = 64,
    parameter int DW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frm_start,
    input  logic [7:0]    frm_sym_num,
    input  logic [DW-1:0] adc_din,
    input  logic          adc_din_vld,
    output logic          adc_dout_rdy,
    output logic [DW-1:0] train_dout,
    output logic          train_dout_vld,
    output logic          train_dout_last,
    output logic [8:0]    train_dout_Index,
    input  logic          train_din_rdy,
    output logic [DW-1:0] fft_dout,
    output logic          fft_dout_vld,
    output logic          fft_dout_last,
    output logic [7:0]    fft_dout_Index,
    output logic [7:0]    fft_dout_sym,
    input  logic          fft_din_rdy,
    output logic          frm_busy,
    output logic          frm_done,
    output logic          frm_err
);

    localparam logic [8:0] TRAIN_LAST = 9'(TRAIN_LEN - 1);
    localparam logic [8:0] CP_LAST    = 9'(CP_LEN - 1);
    localparam logic [8:0] FFT_LAST   = 9'(FFT_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_TRAIN, S_CP, S_BODY, S_DRAIN} state_t;

    state_t     state;
    logic [8:0] cnt;
    logic [7:0] sym;
    logic [7:0] sym_num;
    logic       in_beat;
    logic       train_hs;
    logic       fft_hs;

    always_comb begin
        adc_dout_rdy = 1'b0;
        case (state)
            S_IDLE, S_CP: adc_dout_rdy = 1'b1;
            S_TRAIN:      adc_dout_rdy = !train_dout_vld || train_din_rdy;
            S_BODY:       adc_dout_rdy = !fft_dout_vld || fft_din_rdy;
            default:      adc_dout_rdy = 1'b0;
        endcase
    end

    assign in_beat  = adc_din_vld & adc_dout_rdy;
    assign train_hs = train_dout_vld & train_din_rdy;
    assign fft_hs   = fft_dout_vld & fft_din_rdy;
    assign frm_busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            sym              <= '0;
            sym_num          <= '0;
            train_dout       <= '0;
            train_dout_vld   <= 1'b0;
            train_dout_last  <= 1'b0;
            train_dout_Index <= '0;
            fft_dout         <= '0;
            fft_dout_vld     <= 1'b0;
            fft_dout_last    <= 1'b0;
            fft_dout_Index   <= '0;
            fft_dout_sym     <= '0;
            frm_done         <= 1'b0;
            frm_err          <= 1'b0;
        end else begin
            frm_done <= 1'b0;
            frm_err  <= frm_start && (state != S_IDLE);
            // Handshake clears first so a same-cycle reload below takes priority.
            if (train_hs) train_dout_vld <= 1'b0;
            if (fft_hs)   fft_dout_vld   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (frm_start) begin
                        sym_num <= frm_sym_num;
                        sym     <= '0;
                        state   <= S_TRAIN;
                        if (in_beat) begin
                            train_dout       <= adc_din;
                            train_dout_vld   <= 1'b1;
                            train_dout_Index <= '0;
                            train_dout_last  <= (TRAIN_LAST == '0);
                            cnt              <= 9'd1;
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                S_TRAIN: begin
                    if (in_beat) begin
                        train_dout       <= adc_din;
                        train_dout_vld   <= 1'b1;
                        train_dout_Index <= cnt;
                        train_dout_last  <= (cnt == TRAIN_LAST);
                        if (cnt == TRAIN_LAST) begin
                            cnt   <= '0;
                            sym   <= '0;
                            state <= (sym_num == '0) ? S_DRAIN : S_CP;
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                end
                S_CP: begin
                    if (in_beat) begin
                        if (cnt == CP_LAST) begin
                            cnt   <= '0;
                            state <= S_BODY;
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                end
                S_BODY: begin
                    if (in_beat) begin
                        fft_dout       <= adc_din;
                        fft_dout_vld   <= 1'b1;
                        fft_dout_Index <= cnt[7:0];
                        fft_dout_sym   <= sym;
                        fft_dout_last  <= (cnt == FFT_LAST);
                        if (cnt == FFT_LAST) begin
                            cnt <= '0;
                            if (sym == sym_num - 8'd1) begin
                                state <= S_DRAIN;
                            end else begin
                                sym   <= sym + 8'd1;
                                state <= S_CP;
                            end
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Done is issued in the cycle right after the final output handshake.
                    if ((!train_dout_vld || train_hs) && (!fft_dout_vld || fft_hs)) begin
                        frm_done <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_rx_deframer.sv
// Directed bench for ofdm_rx_deframer: frames with counting ADC data, checked beat by beat.
module tb_ofdm_rx_deframer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frm_start;
    logic [7:0]  frm_sym_num;
    logic [15:0] adc_din;
    logic        adc_din_vld;
    logic        adc_dout_rdy;
    logic [15:0] train_dout;
    logic        train_dout_vld;
    logic        train_dout_last;
    logic [8:0]  train_dout_Index;
    logic        train_din_rdy;
    logic [15:0] fft_dout;
    logic        fft_dout_vld;
    logic        fft_dout_last;
    logic [7:0]  fft_dout_Index;
    logic [7:0]  fft_dout_sym;
    logic        fft_din_rdy;
    logic        frm_busy;
    logic        frm_done;
    logic        frm_err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ofdm_rx_deframer #(.TRAIN_LEN(320), .CP_LEN(16), .FFT_LEN(64), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .frm_start(frm_start), .frm_sym_num(frm_sym_num),
        .adc_din(adc_din), .adc_din_vld(adc_din_vld), .adc_dout_rdy(adc_dout_rdy),
        .train_dout(train_dout), .train_dout_vld(train_dout_vld),
        .train_dout_last(train_dout_last), .train_dout_Index(train_dout_Index),
        .train_din_rdy(train_din_rdy),
        .fft_dout(fft_dout), .fft_dout_vld(fft_dout_vld), .fft_dout_last(fft_dout_last),
        .fft_dout_Index(fft_dout_Index), .fft_dout_sym(fft_dout_sym),
        .fft_din_rdy(fft_din_rdy),
        .frm_busy(frm_busy), .frm_done(frm_done), .frm_err(frm_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: counting data starting at 0, frm_start with sample `pre`.
    // err_at pulses a second frm_start at training index 100; abort_at >= 0 resets
    // while that sample offset (relative to the start sample) is presented.
    task automatic run_frame(input int pre, input int sn, input bit rnd,
                             input bit err_at, input int abort_at);
        int n = 0, tcnt = 0, fcnt = 0, dcnt = 0, ecnt = 0, post = 0;
        int sym, idx;
        bit start_sent = 0, err_sent = 0, beat;
        bit stall_t = 0, stall_f = 0;
        logic [63:0] save_t = '0, save_f = '0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            adc_din     = n[15:0];
            adc_din_vld = 1'b1;
            frm_sym_num = sn[7:0];
            frm_start   = 1'b0;
            if (!start_sent && n == pre) begin
                frm_start  = 1'b1;
                start_sent = 1;
            end else if (err_at && start_sent && !err_sent && n == pre + 100) begin
                frm_start = 1'b1;
                err_sent  = 1;
            end
            rst_n         = !(abort_at >= 0 && start_sent && n == pre + abort_at);
            train_din_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            fft_din_rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (frm_done) dcnt++;
            if (frm_err)  ecnt++;
            if (!start_sent || (frm_start && n == pre))
                check("idle_no_vld", {train_dout_vld, fft_dout_vld}, 2'b00);
            if (stall_t) check("train_hold", {train_dout_vld, train_dout, train_dout_Index, train_dout_last},
                               save_t);
            if (stall_f) check("fft_hold", {fft_dout_vld, fft_dout, fft_dout_Index, fft_dout_sym, fft_dout_last},
                               save_f);
            stall_t = train_dout_vld && !train_din_rdy;
            stall_f = fft_dout_vld && !fft_din_rdy;
            save_t  = {1'b1, train_dout, train_dout_Index, train_dout_last};
            save_f  = {1'b1, fft_dout, fft_dout_Index, fft_dout_sym, fft_dout_last};
            if (rst_n && train_dout_vld && train_din_rdy) begin
                check("train_beat", {train_dout, train_dout_Index, train_dout_last},
                      {16'(pre + tcnt), 9'(tcnt), (tcnt == 319)});
                tcnt++;
            end
            if (rst_n && fft_dout_vld && fft_din_rdy) begin
                sym = fcnt / 64;
                idx = fcnt % 64;
                check("fft_beat", {fft_dout, fft_dout_Index, fft_dout_sym, fft_dout_last},
                      {16'(pre + 320 + sym * 80 + 16 + idx), 8'(idx), 8'(sym), (idx == 63)});
                fcnt++;
            end
            beat = adc_din_vld && adc_dout_rdy;
            @(posedge clk);
            if (beat) n++;
            if (!rst_n) begin
                #1;
                check("abort_state",
                      {train_dout_vld, fft_dout_vld, frm_busy, frm_done, adc_dout_rdy}, 5'b00001);
                check("abort_fft_cnt", 64'(fcnt), 64'(64 + 10 - 1));
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (dcnt > 0) begin
                post++;
                if (post > 4) break;
            end
        end
        check("train_count", 64'(tcnt), 64'd320);
        check("fft_count", 64'(fcnt), 64'(sn * 64));
        check("done_count", 64'(dcnt), 64'd1);
        check("err_count", 64'(ecnt), 64'(err_at));
        check("busy_end", {63'd0, frm_busy}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; frm_start = 1'b0; frm_sym_num = '0; adc_din = '0; adc_din_vld = 1'b0;
        train_din_rdy = 1'b1; fft_din_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", {63'd0, adc_dout_rdy}, 64'd1);
        check("rst_vld", {train_dout_vld, fft_dout_vld}, 64'd0);
        check("rst_flags", {frm_busy, frm_done, frm_err}, 64'd0);
        check("rst_data", {train_dout, fft_dout, train_dout_Index, fft_dout_Index, fft_dout_sym}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(0,  2, 1'b0, 1'b0, -1);
        run_frame(50, 2, 1'b0, 1'b0, -1);
        run_frame(0,  0, 1'b0, 1'b0, -1);
        run_frame(0,  2, 1'b1, 1'b0, -1);
        run_frame(0,  2, 1'b0, 1'b1, -1);
        run_frame(0,  2, 1'b0, 1'b0, 320 + 80 + 16 + 10);
        run_frame(0,  2, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
